// File: rtl/s2p_framer_if.sv
// Serial-in / parallel-out stream bundle for s2p_framer: serial frame input on one side,
// parallel word with valid/ready handshake on the other.
interface s2p_framer_if #(
  parameter int WIDTH = 16
);
  logic             din;
  logic             fs;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;

  // Driver of the serial stream and consumer of the parallel words.
  modport master (
    output din, fs, dout_ready,
    input  dout, dout_valid
  );

  // The framer itself.
  modport slave (
    input  din, fs, dout_ready,
    output dout, dout_valid
  );
endinterface

// File: rtl/s2p_framer.sv
// Frame-synchronised serial-to-parallel converter: after an fs strobe, WIDTH bits (MSB first)
// are assembled into a word and presented on a valid/ready output with sticky error flags.
module s2p_framer #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  s2p_framer_if.slave   bus,
  input  logic          clr_err,
  output logic [4:0]    count,
  output logic          sync_err,
  output logic          overrun
);

  typedef enum logic {HUNT, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             sync_err_q, sync_err_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {sreg_q[WIDTH-2:0], bus.din};

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    dout_d     = dout_q;
    cnt_d      = cnt_q;
    // A transfer drops valid; a completing word below re-asserts it, and set beats clear.
    valid_d    = valid_q & ~bus.dout_ready;
    sync_err_d = sync_err_q & ~clr_err;
    overrun_d  = overrun_q & ~clr_err;
    unique case (state_q)
      HUNT: begin
        cnt_d = 5'd0;
        if (bus.fs) begin
          state_d = SHIFT;
          sreg_d  = '0;
        end
      end
      SHIFT: begin
        if (bus.fs) begin
          sync_err_d = 1'b1;
          sreg_d     = '0;
          cnt_d      = 5'd0;
        end else begin
          sreg_d = shifted;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'(WIDTH - 1)) begin
            state_d = HUNT;
            dout_d  = shifted;
            valid_d = 1'b1;
            if (valid_q && !bus.dout_ready) overrun_d = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HUNT;
      sreg_q     <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= 5'd0;
      sync_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign count          = cnt_q;
  assign sync_err       = sync_err_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_s2p_framer.sv
// Directed self-checking bench for s2p_framer: one task per scenario, hand-computed expectations.
module tb_s2p_framer;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_err = 1'b0;
  logic [4:0] count;
  logic       sync_err;
  logic       overrun;
  int         checks = 0;
  int         errors = 0;

  s2p_framer_if #(.WIDTH(W)) bus ();

  s2p_framer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .clr_err  (clr_err),
    .count    (count),
    .sync_err (sync_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fs strobe then WIDTH bits MSB first; optionally raise ready/clr_err on the last data bit.
  task automatic send_frame(input logic [W-1:0] word, input logic rdy_last, input logic clr_last);
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    for (int k = 0; k < W; k++) begin
      bus.din = word[W-1-k];
      if (k == W - 1) begin
        if (rdy_last) bus.dout_ready = 1'b1;
        if (clr_last) clr_err = 1'b1;
      end
      tick();
    end
    clr_err = 1'b0;
    bus.din = 1'b0;
  endtask

  task automatic test_reset();
    bus.din = 1'b0; bus.fs = 1'b0; bus.dout_ready = 1'b0;
    rst = 1'b0;
    #3;
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 0000", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.dout_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if ({sync_err, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {sync_err, overrun}); end
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL hunt_count: got %0d expected 0", count); end
  endtask

  task automatic test_single();
    logic [W-1:0] word = 16'hA5C3;
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL single_count_fs: got %0d expected 0", count); end
    for (int k = 0; k < W; k++) begin
      bus.din = word[W-1-k];
      tick();
      if (k == 7) begin
        checks++; if (count !== 5'd8) begin errors++; $display("[TB] FAIL single_count_mid: got %0d expected 8", count); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_partial_valid: got %b expected 0", bus.dout_valid); end
      end
    end
    bus.din = 1'b0;
    checks++; if (bus.dout !== 16'hA5C3) begin errors++; $display("[TB] FAIL single_dout: got %h expected a5c3", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", bus.dout_valid); end
    checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL single_count_full: got %0d expected 16", count); end
    checks++; if ({sync_err, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL single_flags: got %b expected 00", {sync_err, overrun}); end
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL single_count_after: got %0d expected 0", count); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_hold_valid: got %b expected 1", bus.dout_valid); end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_accept: got %b expected 0", bus.dout_valid); end
    checks++; if (bus.dout !== 16'hA5C3) begin errors++; $display("[TB] FAIL single_dout_hold: got %h expected a5c3", bus.dout); end
  endtask

  task automatic test_back_to_back();
    bus.dout_ready = 1'b1;
    send_frame(16'h1111, 1'b0, 1'b0);
    checks++; if (bus.dout !== 16'h1111) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 1111", bus.dout); end
    send_frame(16'hFFFF, 1'b0, 1'b0);
    checks++; if (bus.dout !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_second: got %h expected ffff", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", bus.dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); end
    tick();
    bus.dout_ready = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", bus.dout_valid); end
  endtask

  task automatic test_overrun();
    send_frame(16'h0001, 1'b0, 1'b0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_first: got %b expected 0", overrun); end
    send_frame(16'h8000, 1'b0, 1'b0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
    checks++; if (bus.dout !== 16'h8000) begin errors++; $display("[TB] FAIL ovr_dout: got %h expected 8000", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid: got %b expected 1", bus.dout_valid); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); end
    send_frame(16'h0002, 1'b0, 1'b1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set_beats_clr: got %b expected 1", overrun); end
    clr_err = 1'b1; bus.dout_ready = 1'b1;
    tick();
    clr_err = 1'b0; bus.dout_ready = 1'b0;
    checks++; if ({bus.dout_valid, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL ovr_cleanup: got %b expected 00", {bus.dout_valid, overrun}); end
  endtask

  task automatic test_resync();
    logic [W-1:0] word = 16'h00FF;
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    bus.din = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    checks++; if (sync_err !== 1'b1) begin errors++; $display("[TB] FAIL resync_err: got %b expected 1", sync_err); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL resync_count: got %0d expected 0", count); end
    for (int k = 0; k < W; k++) begin
      bus.din = word[W-1-k];
      tick();
      if (k == 6) begin
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL resync_no_word_e16: got %b expected 0", bus.dout_valid); end
      end
    end
    checks++; if (bus.dout !== 16'h00FF) begin errors++; $display("[TB] FAIL resync_dout: got %h expected 00ff", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL resync_valid: got %b expected 1", bus.dout_valid); end
    clr_err = 1'b1; bus.dout_ready = 1'b1;
    tick();
    clr_err = 1'b0; bus.dout_ready = 1'b0;
    // fs landing on what would be the last data bit edge must abort the frame.
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    bus.din = 1'b1;
    for (int k = 0; k < W - 1; k++) tick();
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    checks++; if ({sync_err, bus.dout_valid} !== 2'b10) begin errors++; $display("[TB] FAIL resync_last_edge: got %b expected 10", {sync_err, bus.dout_valid}); end
    checks++; if (bus.dout !== 16'h00FF) begin errors++; $display("[TB] FAIL resync_partial_dout: got %h expected 00ff", bus.dout); end
    word = 16'hBEEF;
    for (int k = 0; k < W; k++) begin
      bus.din = word[W-1-k];
      tick();
    end
    checks++; if (bus.dout !== 16'hBEEF) begin errors++; $display("[TB] FAIL resync_after_last: got %h expected beef", bus.dout); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] word = 16'h1234;
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.din = word[W-1-k];
      tick();
    end
    checks++; if (count !== 5'd7) begin errors++; $display("[TB] FAIL arst_count_pre: got %0d expected 7", count); end
    rst = 1'b0;
    #2;
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("[TB] FAIL arst_dout: got %h expected 0000", bus.dout); end
    checks++; if ({bus.dout_valid, sync_err, overrun} !== 3'b000) begin errors++; $display("[TB] FAIL arst_flags: got %b expected 000", {bus.dout_valid, sync_err, overrun}); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL arst_count: got %0d expected 0", count); end
    #2;
    rst = 1'b1;
    bus.din = 1'b0;
    send_frame(16'h1234, 1'b0, 1'b0);
    checks++; if (bus.dout !== 16'h1234) begin errors++; $display("[TB] FAIL arst_frame: got %h expected 1234", bus.dout); end
    checks++; if ({bus.dout_valid, sync_err} !== 2'b10) begin errors++; $display("[TB] FAIL arst_frame_flags: got %b expected 10", {bus.dout_valid, sync_err}); end
  endtask

  task automatic test_simultaneous();
    send_frame(16'h0004, 1'b1, 1'b0);
    bus.dout_ready = 1'b0;
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL simul_valid: got %b expected 1", bus.dout_valid); end
    checks++; if (bus.dout !== 16'h0004) begin errors++; $display("[TB] FAIL simul_dout: got %h expected 0004", bus.dout); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL simul_overrun: got %b expected 0", overrun); end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL simul_drain: got %b expected 0", bus.dout_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_resync();
    test_async_reset();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/s2p_framer.md
S2P_FRAMER -- requirements
Module: s2p_framer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the frame payload width in bits (legal range 2..31).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port din, input, 1 bit: serial data, MSB first.
REQ-005 The block SHALL have port fs, input, 1 bit: frame-sync strobe, high for one cycle before each frame.
REQ-006 The block SHALL have port dout_ready, input, 1 bit: downstream accepts dout when high with dout_valid.
REQ-007 The block SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-008 The block SHALL have port dout, output, WIDTH bits: last completed parallel word.
REQ-009 The block SHALL have port dout_valid, output, 1 bit: dout holds an unaccepted word.
REQ-010 The block SHALL have port count, output, 5 bits: bits received in the current frame, 0..WIDTH.
REQ-011 The block SHALL have port sync_err, output, 1 bit: sticky; fs arrived mid-frame.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky; a word completed while dout_valid was still high.

Function
REQ-013 The FSM SHALL have two states, HUNT and SHIFT, and SHALL reset to HUNT.
REQ-014 In HUNT, fs=1 at edge N SHALL move to SHIFT with count=0 and clear the shift register; din at edge N is ignored.
REQ-015 In HUNT, fs=0 SHALL keep HUNT; din is ignored and count holds 0.
REQ-016 In SHIFT without fs, each edge SHALL shift din into the shift register LSB (MSB-first frame) and increment count.
REQ-017 The bit sampled at edge N+k (k=1..WIDTH) SHALL be payload bit WIDTH-k.
REQ-018 At edge N+WIDTH the completed word SHALL be loaded into dout, dout_valid SHALL be set, and the FSM SHALL return to HUNT.
REQ-019 At edge N+WIDTH, count SHALL read WIDTH for that one cycle, then 0.
REQ-020 Completion latency SHALL be 0 cycles after the last data bit edge: dout and dout_valid are visible right after edge N+WIDTH.
REQ-021 fs sampled in HUNT at edge N+WIDTH+1 SHALL start the next frame, supporting a continuous period of WIDTH+1 cycles with no gaps.
REQ-022 fs=1 in SHIFT (count<WIDTH, including the last data bit edge) SHALL set sync_err, discard the partial word, and restart with count=0; that edge carries no data.
REQ-023 A partial frame SHALL never update dout or dout_valid.
REQ-024 dout_valid=1 with dout_ready=1 at an edge SHALL clear dout_valid (the transfer); dout SHALL hold its value otherwise.
REQ-025 If a word completes while dout_valid=1 and dout_ready=0, the block SHALL set overrun, overwrite dout with the new word, and keep dout_valid=1.
REQ-026 If a word completes at the same edge as a transfer, the new word SHALL load, dout_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-027 clr_err=1 SHALL clear sync_err and overrun at that edge; a same-edge set event SHALL win over the clear.
REQ-028 dout_ready SHALL be ignored while dout_valid=0.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force: state=HUNT, shift register=0, dout=0, dout_valid=0, count=0, sync_err=0, overrun=0.
REQ-030 Reset release SHALL take effect at the first rising clk edge with rst=1; any partial frame in progress at reset SHALL be lost.

Verification
REQ-031 Single frame: fs at edge 0, din=0xA5C3 MSB-first on edges 1..16 -> dout=0xA5C3, dout_valid=1 after edge 16, count=16 for one cycle, no error flags set.
REQ-032 Back-to-back: 0x1111 then 0xFFFF at a 17-cycle period, dout_ready held 1 -> both words delivered in order, overrun=0.
REQ-033 Overrun: two frames (0x0001, 0x8000) with dout_ready=0 -> overrun=1, dout=0x8000; then clr_err pulse -> overrun=0.
REQ-034 Resync: fs at edge 0, fs again at edge 9, then 16 bits of 0x00FF -> sync_err=1, dout=0x00FF after edge 25, no word emitted at edge 16.
REQ-035 Async reset: rst pulled low mid-frame at count=7 with no clock edge -> all outputs 0 immediately; next fs+frame 0x1234 decodes correctly.
REQ-036 Simultaneous: a word completes at the same edge dout_ready accepts the prior word -> dout_valid stays 1, new word on dout, overrun=0.
